// File: rtl/pipe_pkg.sv
// Shared definitions for the M-stage memory controller: FSM state encoding and default widths.
package pipe_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter for an outstanding memory request; expire_o marks the last permitted cycle.
module mem_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int           CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage access controller: converts the EX/MEM load/store into a req/ack memory
// transaction, stalls the pipe while it is outstanding and forwards the result to MEM/WB.
module mem_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              err_o
);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                wd_clr, wd_en, wd_expire;
    logic                access;

    assign access = mem_rd_i | mem_wr_i;

    mem_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        err_d   = err_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_wr_i;   // rd+wr together resolves to a write
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wd_clr  = 1'b1;
                end
            end
            ST_REQ: begin
                wd_en = 1'b1;
                // ack is checked first so an ack on the final cycle beats the timeout
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rdata_d = we_q ? '0 : mem_rdata_i;
                end else if (wd_expire) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // DONE releases the pipe so the access retires in the same cycle as valid_o
    assign stall_o     = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign valid_o     = valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: load, store, timeout, ack-at-timeout, reset mid-REQ, back-to-back.
module tb_mem_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_rd_i, mem_wr_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        valid_o, err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_stage_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_rd_i    (mem_rd_i),
        .mem_wr_i    (mem_wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .rdata_o     (rdata_o),
        .valid_o     (valid_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one access from the current IDLE cycle until valid_o; ack_at is the 1-based REQ cycle
    // in which ack is driven (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] rdv,
                              output int stall_n, output int req_n, output logic stable,
                              output logic done_stall, output logic err_v,
                              output logic [31:0] rd_out, output logic got_valid);
        stall_n = 0; req_n = 0; stable = 1'b1; done_stall = 1'b0;
        err_v = 1'b0; rd_out = '0; got_valid = 1'b0;
        mem_rd_i = rd; mem_wr_i = wr; addr_i = a; wdata_i = wd;
        #1;
        if (stall_o) stall_n++;
        for (int c = 0; c < 40 && !got_valid; c++) begin
            step();
            mem_ack_i = 1'b0;
            mem_rdata_i = '0;
            if (valid_o) begin
                got_valid = 1'b1;
                done_stall = stall_o;
                err_v = err_o;
                rd_out = rdata_o;
                mem_rd_i = 1'b0;
                mem_wr_i = 1'b0;
            end else begin
                if (mem_req_o) begin
                    req_n++;
                    if (mem_we_o !== wr || mem_addr_o !== a || mem_wdata_o !== wd) stable = 1'b0;
                    if (req_n == ack_at) begin
                        mem_ack_i = 1'b1;
                        mem_rdata_i = rdv;
                    end
                end
                if (stall_o) stall_n++;
            end
        end
    endtask

    task automatic access_checks(input string nm, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                                 input logic [31:0] rdv, input int exp_stall, input int exp_req,
                                 input logic exp_err, input logic [31:0] exp_rdata);
        int          s_n, r_n;
        logic        st, ds, e, gv;
        logic [31:0] ro;
        run_access(rd, wr, a, wd, ack_at, rdv, s_n, r_n, st, ds, e, ro, gv);
        check({nm, " valid"}, 32'(gv), 32'd1);
        check({nm, " stall_cycles"}, 32'(s_n), 32'(exp_stall));
        check({nm, " req_cycles"}, 32'(r_n), 32'(exp_req));
        check({nm, " req_stable"}, 32'(st), 32'd1);
        check({nm, " stall_at_done"}, 32'(ds), 32'd0);
        check({nm, " err"}, 32'(e), 32'(exp_err));
        check({nm, " rdata"}, ro, exp_rdata);
    endtask

    initial begin
        rst_i = 1'b0;
        mem_rd_i = 1'b0; mem_wr_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #12;
        check("reset req", 32'(mem_req_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        check("idle stall", 32'(stall_o), 32'd0);

        // load: ack in 3rd REQ cycle
        access_checks("load", 1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, 3, 1'b0, 32'hDEADBEEF);
        step();
        check("load valid_pulse", 32'(valid_o), 32'd0);

        // store: ack in 2nd REQ cycle, read data bus ignored
        access_checks("store", 1'b0, 1'b1, 32'h40, 32'h1234, 2, 32'hFFFFFFFF, 3, 2, 1'b0, 32'h0);
        step();

        // timeout: never acked
        access_checks("timeout", 1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h0, 17, 16, 1'b1, 32'h0);
        step();
        check("timeout valid_pulse", 32'(valid_o), 32'd0);
        check("timeout err_sticky", 32'(err_o), 32'd1);
        check("timeout stall_release", 32'(stall_o), 32'd0);

        // reset in the middle of REQ
        mem_rd_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h77;
        step();
        step();
        check("midreq req_before", 32'(mem_req_o), 32'd1);
        #2;
        rst_i = 1'b0;
        mem_rd_i = 1'b0;
        #1;
        check("midreq req_async", 32'(mem_req_o), 32'd0);
        check("midreq err_clr", 32'(err_o), 32'd0);
        check("midreq addr_clr", mem_addr_o, 32'd0);
        check("midreq wdata_clr", mem_wdata_o, 32'd0);
        check("midreq stall", 32'(stall_o), 32'd0);
        step();
        #2;
        rst_i = 1'b1;
        step();
        check("post_reset req", 32'(mem_req_o), 32'd0);

        // ack on the 16th REQ cycle beats the watchdog
        access_checks("ack_at_timeout", 1'b1, 1'b0, 32'h300, 32'h0, 16, 32'hCAFEF00D,
                      17, 16, 1'b0, 32'hCAFEF00D);
        step();
        // rd+wr together behaves as a write; minimum occupancy
        access_checks("rdwr", 1'b1, 1'b1, 32'h44, 32'hA5A5, 1, 32'h12345678, 2, 1, 1'b0, 32'h0);
        step();

        // spurious ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        check("spurious req", 32'(mem_req_o), 32'd0);
        check("spurious valid", 32'(valid_o), 32'd0);
        check("spurious rdata", rdata_o, 32'd0);
        step();

        // back-to-back loads with an IDLE cycle in between
        access_checks("b2b_1", 1'b1, 1'b0, 32'h500, 32'h0, 1, 32'h11112222, 2, 1, 1'b0, 32'h11112222);
        step();
        check("b2b idle_req", 32'(mem_req_o), 32'd0);
        check("b2b idle_valid", 32'(valid_o), 32'd0);
        access_checks("b2b_2", 1'b1, 1'b0, 32'h504, 32'h0, 3, 32'h33334444, 4, 3, 1'b0, 32'h33334444);
        check("final err", 32'(err_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
